// File: rtl/cpu_fetch_sequencer.sv
// CPU fetch front end: frame counter, PC, one/two-word fetch and circular call stack.
// Optional stack depth status flags when CPU_FETCH_STACK_STATUS_EN is defined.
`default_nettype none

module cpu_fetch_sequencer #(
   parameter int ADDR_WIDTH  = 12,
   parameter int STACK_DEPTH = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [3:0]            data_in,
   input  logic                  cond_true,
   input  logic                  isz_nonzero,
   input  logic [7:0]            pair_value,
   output logic [2:0]            cycle,
   output logic                  sync,
   output logic [3:0]            data_out,
   output logic                  data_oe,
   output logic [7:0]            inst,
   output logic [7:0]            inst2,
   output logic                  second_word,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  stack_overflow,
   output logic                  stack_underflow
);

   localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic {FETCH1 = 1'b0, FETCH2 = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [2:0]            cycle_q;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [7:0]            inst_q, inst2_q;
   logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
   logic [SP_W-1:0]       sp_q, sp_inc, sp_dec;
   logic                  push, pop;

   logic [3:0]            w_opr;
   logic                  w_two_word;
   logic [ADDR_WIDTH-1:0] w_p1, w_long, w_page, w_jin;
   logic [11:0]           w_pc_lo;

   assign w_opr      = inst_q[7:4];
   assign w_two_word = (w_opr == 4'h1) || (w_opr == 4'h2 && !inst_q[0]) ||
                       (w_opr == 4'h4) || (w_opr == 4'h5) || (w_opr == 4'h7);
   assign w_p1       = pc_q + ADDR_WIDTH'(1);
   assign w_long     = ADDR_WIDTH'({inst_q[3:0], inst2_q});
   assign sp_inc     = (sp_q == SP_W'(STACK_DEPTH - 1)) ? '0 : sp_q + SP_W'(1);
   assign sp_dec     = (sp_q == '0) ? SP_W'(STACK_DEPTH - 1) : sp_q - SP_W'(1);

   // Short jumps keep the page of p1, so a second word at page end lands in the next page.
   always_comb begin
      w_page      = w_p1;
      w_page[7:0] = inst2_q;
      w_jin       = w_p1;
      w_jin[7:0]  = pair_value;
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      pop     = 1'b0;
      if (cycle_q == 3'd7) begin
         pc_d = w_p1;
         case (state_q)
            FETCH1: begin
               if (w_two_word) state_d = FETCH2;
               if (w_opr == 4'h3 && inst_q[0]) begin
                  pc_d = w_jin;
               end else if (w_opr == 4'hC) begin
                  pop  = 1'b1;
                  pc_d = stack_q[sp_dec];
               end
            end
            FETCH2: begin
               state_d = FETCH1;
               case (w_opr)
                  4'h4: pc_d = w_long;
                  4'h5: begin
                     push = 1'b1;
                     pc_d = w_long;
                  end
                  4'h1: if (cond_true)   pc_d = w_page;
                  4'h7: if (isz_nonzero) pc_d = w_page;
                  default: pc_d = w_p1;
               endcase
            end
            default: state_d = FETCH1;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cycle_q <= 3'd0;
         state_q <= FETCH1;
         pc_q    <= '0;
         inst_q  <= 8'h00;
         inst2_q <= 8'h00;
      end else begin
         cycle_q <= cycle_q + 3'd1;
         state_q <= state_d;
         pc_q    <= pc_d;
         if (cycle_q == 3'd3) begin
            if (state_q == FETCH1) inst_q[7:4]  <= data_in;
            else                   inst2_q[7:4] <= data_in;
         end
         if (cycle_q == 3'd4) begin
            if (state_q == FETCH1) inst_q[3:0]  <= data_in;
            else                   inst2_q[3:0] <= data_in;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sp_q <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      end else if (push) begin
         stack_q[sp_q] <= w_p1;
         sp_q          <= sp_inc;
      end else if (pop) begin
         sp_q <= sp_dec;
      end
   end

`ifdef CPU_FETCH_STACK_STATUS_EN
   localparam int CNT_W = $clog2(STACK_DEPTH + 1);
   logic [CNT_W-1:0] count_q;
   logic             ovf_q, udf_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else if (push) begin
         if (count_q == CNT_W'(STACK_DEPTH)) ovf_q <= 1'b1;
         else                                count_q <= count_q + CNT_W'(1);
      end else if (pop) begin
         if (count_q == '0) udf_q <= 1'b1;
         else               count_q <= count_q - CNT_W'(1);
      end
   end

   assign stack_overflow  = ovf_q;
   assign stack_underflow = udf_q;
`else
   assign stack_overflow  = 1'b0;
   assign stack_underflow = 1'b0;
`endif

   // Only the low three nibbles ever go out on the bus.
   if (ADDR_WIDTH >= 12) begin : g_pc_wide
      assign w_pc_lo = pc_q[11:0];
   end else begin : g_pc_narrow
      assign w_pc_lo = {4'h0, pc_q[7:0]};
   end

   always_comb begin
      data_out = 4'h0;
      case (cycle_q)
         3'd0:    data_out = w_pc_lo[3:0];
         3'd1:    data_out = w_pc_lo[7:4];
         3'd2:    data_out = w_pc_lo[11:8];
         default: data_out = 4'h0;
      endcase
   end

   assign cycle       = cycle_q;
   assign sync        = (cycle_q != 3'd7);
   assign data_oe     = (cycle_q < 3'd3);
   assign inst        = inst_q;
   assign inst2       = inst2_q;
   assign second_word = (state_q == FETCH2);
   assign pc          = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_fetch_sequencer.sv
// Bench for cpu_fetch_sequencer: ROM image plus frame-level reference model, directed then random programs.
`default_nettype none

module tb_cpu_fetch_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [3:0]  data_in;
   logic        cond_true, isz_nonzero;
   logic [7:0]  pair_value;
   logic [2:0]  cycle;
   logic        sync, data_oe, second_word, stack_overflow, stack_underflow;
   logic [3:0]  data_out;
   logic [7:0]  inst, inst2;
   logic [11:0] pc;

   cpu_fetch_sequencer #(.ADDR_WIDTH(12), .STACK_DEPTH(3)) dut (
      .clock(clock), .reset_n(reset_n), .data_in(data_in), .cond_true(cond_true),
      .isz_nonzero(isz_nonzero), .pair_value(pair_value), .cycle(cycle), .sync(sync),
      .data_out(data_out), .data_oe(data_oe), .inst(inst), .inst2(inst2),
      .second_word(second_word), .pc(pc), .stack_overflow(stack_overflow),
      .stack_underflow(stack_underflow)
   );

   initial forever #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  rom [4096];
   logic [2:0]  m_cycle;
   logic [11:0] m_pc;
   bit          m_second;
   logic [7:0]  m_inst, m_inst2;
   logic [11:0] m_stk [3];
   int          m_sp, m_cnt;
   bit          m_ovf, m_udf;
   bit          f_cond, f_isz;
   logic [7:0]  f_pair;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cycle = 3'd0; m_pc = 12'h000; m_second = 1'b0;
      m_inst = 8'h00; m_inst2 = 8'h00;
      for (int i = 0; i < 3; i++) m_stk[i] = 12'h000;
      m_sp = 0; m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
   endtask

   task automatic m_push(input logic [11:0] v);
      m_stk[m_sp] = v;
      m_sp = (m_sp + 1) % 3;
      if (m_cnt == 3) m_ovf = 1'b1; else m_cnt++;
   endtask

   task automatic m_pop(output logic [11:0] v);
      m_sp = (m_sp + 2) % 3;
      v = m_stk[m_sp];
      if (m_cnt == 0) m_udf = 1'b1; else m_cnt--;
   endtask

   task automatic check_outputs();
      logic [3:0] exp_do;
      case (m_cycle)
         3'd0:    exp_do = m_pc[3:0];
         3'd1:    exp_do = m_pc[7:4];
         3'd2:    exp_do = m_pc[11:8];
         default: exp_do = 4'h0;
      endcase
      chk("cycle", cycle, m_cycle);
      chk("sync", sync, (m_cycle != 3'd7));
      chk("data_oe", data_oe, (m_cycle < 3'd3));
      chk("data_out", data_out, exp_do);
      chk("second_word", second_word, m_second);
      chk("pc", pc, m_pc);
      chk("inst", inst, m_inst);
      chk("inst2", inst2, m_inst2);
`ifdef CPU_FETCH_STACK_STATUS_EN
      chk("overflow", stack_overflow, m_ovf);
      chk("underflow", stack_underflow, m_udf);
`else
      chk("overflow", stack_overflow, 1'b0);
      chk("underflow", stack_underflow, 1'b0);
`endif
   endtask

   task automatic model_advance();
      logic [11:0] p1, v;
      logic [3:0]  opr;
      if (m_cycle == 3'd3) begin
         if (!m_second) m_inst[7:4] = data_in; else m_inst2[7:4] = data_in;
      end else if (m_cycle == 3'd4) begin
         if (!m_second) m_inst[3:0] = data_in; else m_inst2[3:0] = data_in;
      end else if (m_cycle == 3'd7) begin
         opr = m_inst[7:4];
         p1  = m_pc + 12'd1;
         if (m_second) begin
            m_second = 1'b0;
            if (opr == 4'h4) m_pc = {m_inst[3:0], m_inst2};
            else if (opr == 4'h5) begin
               m_push(p1);
               m_pc = {m_inst[3:0], m_inst2};
            end
            else if ((opr == 4'h1 && cond_true) || (opr == 4'h7 && isz_nonzero))
               m_pc = {p1[11:8], m_inst2};
            else m_pc = p1;
         end else begin
            m_second = (opr == 4'h1 || opr == 4'h4 || opr == 4'h5 || opr == 4'h7 ||
                        (opr == 4'h2 && !m_inst[0]));
            if (opr == 4'h3 && m_inst[0]) m_pc = {p1[11:8], pair_value};
            else if (opr == 4'hC) begin
               m_pop(v);
               m_pc = v;
            end
            else m_pc = p1;
         end
      end
      m_cycle = m_cycle + 3'd1;
   endtask

   // One subcycle: check at the negedge, drive, advance the model at the posedge.
   task automatic step();
      logic [7:0] b;
      check_outputs();
      b = rom[m_pc];
      if (m_cycle == 3'd3)      data_in = b[7:4];
      else if (m_cycle == 3'd4) data_in = b[3:0];
      else                      data_in = 4'($urandom);
      if (m_cycle == 3'd7) begin
         cond_true = f_cond; isz_nonzero = f_isz; pair_value = f_pair;
      end else begin
         cond_true = 1'($urandom); isz_nonzero = 1'($urandom); pair_value = 8'($urandom);
      end
      @(posedge clock);
      model_advance();
      @(negedge clock);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n * 8; i++) step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; data_in = 4'h0; cond_true = 1'b0; isz_nonzero = 1'b0; pair_value = 8'h00;
      f_cond = 1'b1; f_isz = 1'b0; f_pair = 8'h00;
      model_reset();
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
      rom[12'h002] = 8'h4A; rom[12'h003] = 8'h37;
      rom[12'hA37] = 8'h40; rom[12'hA38] = 8'hFE;
      rom[12'h0FE] = 8'h14; rom[12'h0FF] = 8'h10;
      rom[12'h110] = 8'h40; rom[12'h111] = 8'hFE;
      rom[12'h100] = 8'h40; rom[12'h101] = 8'h10;
      rom[12'h010] = 8'h55; rom[12'h011] = 8'h20;
      rom[12'h520] = 8'hC0;
      rom[12'h012] = 8'h50; rom[12'h013] = 8'h30;
      rom[12'h030] = 8'h50; rom[12'h031] = 8'h40;
      rom[12'h040] = 8'h50; rom[12'h041] = 8'h50;
      rom[12'h050] = 8'h50; rom[12'h051] = 8'h60;
      rom[12'h060] = 8'hC0; rom[12'h052] = 8'hC0;
      rom[12'h042] = 8'hC0; rom[12'h032] = 8'hC0;

      repeat (3) @(negedge clock);
      check_outputs();
      reset_n = 1'b1;

      frames(2);  chk("nop_pc", pc, 12'h002);
      frames(2);  chk("jun_pc", pc, 12'hA37);
                  chk("jun_inst2", inst2, 8'h37);
                  chk("jun_state", second_word, 1'b0);
      frames(2);
      frames(2);  chk("jcn_taken_pc", pc, 12'h110);
      f_cond = 1'b0;
      frames(2);
      frames(2);  chk("jcn_not_taken_pc", pc, 12'h100);
      frames(2);
      frames(2);  chk("jms_pc", pc, 12'h520);
      frames(1);  chk("bbl_pc", pc, 12'h012);
      frames(8);  chk("nested_jms_pc", pc, 12'h060);
`ifdef CPU_FETCH_STACK_STATUS_EN
      chk("ovf_after_4_push", stack_overflow, 1'b1);
`endif
      frames(3);  chk("third_return_pc", pc, 12'h032);
      frames(1);  chk("wrapped_return_pc", pc, 12'h052);
`ifdef CPU_FETCH_STACK_STATUS_EN
      chk("udf_after_4_pop", stack_underflow, 1'b1);
`endif

      for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
      repeat (150) begin
         f_cond = 1'($urandom); f_isz = 1'($urandom); f_pair = 8'($urandom);
         frames(1);
      end

      if (m_second) frames(1);
      rom[m_pc] = 8'h72;
      repeat (11) step();
      chk("pre_reset_fetch2", second_word, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      chk("async_pc", pc, 12'h000);
      chk("async_cycle", cycle, 3'd0);
      chk("async_inst", inst, 8'h00);
      chk("async_inst2", inst2, 8'h00);
      chk("async_state", second_word, 1'b0);
      chk("async_data_out", data_out, 4'h0);
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      frames(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
